// File: rtl/sobel_pkg.sv
// Shared constants and the FSM state encoding for the Sobel engine.
//   IMG_W / IMG_H : default frame size in pixels (IMG_W a power of two)
//   PIX_W         : gray pixel width
//   ADDR_W        : width of the linear row*IMG_W+col address
package sobel_pkg;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int PIX_W  = 4;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator.
//   win     : nine pixels p0..p8, row-major, p4 is the centre
//   gx_out  : |Gx| >> 2
//   gy_out  : |Gy| >> 2
//   mag_out : (|Gx| + |Gy|) >> 2, saturated to the pixel maximum
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic [8:0][PIX_W-1:0] win,
  output logic [PIX_W-1:0]      gx_out,
  output logic [PIX_W-1:0]      gy_out,
  output logic [PIX_W-1:0]      mag_out
);
  // Four weighted pixels fit in PIX_W+2 bits; one more for headroom.
  localparam int GW = PIX_W + 3;

  logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [GW-1:0] gx_abs, gy_abs;
  logic [GW:0]   sum;
  logic [GW:0]   sum_sc;

  always_comb begin
    gx_pos = GW'(win[2]) + (GW'(win[5]) << 1) + GW'(win[8]);
    gx_neg = GW'(win[0]) + (GW'(win[3]) << 1) + GW'(win[6]);
    gy_pos = GW'(win[6]) + (GW'(win[7]) << 1) + GW'(win[8]);
    gy_neg = GW'(win[0]) + (GW'(win[1]) << 1) + GW'(win[2]);
    // |a-b| without going through a signed intermediate
    gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
    sum    = {1'b0, gx_abs} + {1'b0, gy_abs};
    sum_sc = sum >> 2;
    // |G| <= 4*max_pix, so the per-axis shift can never overflow PIX_W
    gx_out  = PIX_W'(gx_abs >> 2);
    gy_out  = PIX_W'(gy_abs >> 2);
    mag_out = (sum_sc > (GW+1)'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : PIX_W'(sum_sc);
  end
endmodule

// File: rtl/sobel_engine.sv
// Frame-level Sobel engine: walks every pixel of the gray memory, fetches
// the 3x3 window of interior pixels, and writes |Gx|, |Gy| and magnitude.
// Border pixels are written as zero without any reads.
//   clk, rst     : clock, asynchronous active-low reset
//   start        : frame request, only looked at in IDLE
//   rd_addr/data : gray memory port, data one cycle after address
//   wr_en/addr   : result write strobe and pixel address
//   gx/gy/mag_out: results, stable while wr_en is high
//   done         : one-cycle pulse after the last pixel is written
module sobel_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W = sobel_pkg::IMG_W,
  parameter int IMG_H = sobel_pkg::IMG_H,
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  gx_out,
  output logic [PIX_W-1:0]  gy_out,
  output logic [PIX_W-1:0]  mag_out,
  output logic              done
);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H-1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       pix_q, pix_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [3:0]              fcnt_q, fcnt_d;
  logic [8:0][PIX_W-1:0]   win_q, win_d;
  logic                    wr_en_q, wr_en_d;
  logic                    done_q, done_d;
  logic [PIX_W-1:0]        gx_q, gx_d, gy_q, gy_d, mag_q, mag_d;
  logic [PIX_W-1:0]        k_gx, k_gy, k_mag;
  logic [ADDR_W-1:0]       nxt_pix;
  logic                    enter;

  // Address of window pixel k (0..8) around centre p
  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] p, input int k);
    return ADDR_W'(int'(p) + (k/3 - 1)*IMG_W + (k%3) - 1);
  endfunction

  function automatic logic is_border(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] col, row;
    col = p & ADDR_W'(IMG_W-1);
    row = p >> COL_W;
    return (row == '0) || (row == ADDR_W'(IMG_H-1)) ||
           (col == '0) || (col == ADDR_W'(IMG_W-1));
  endfunction

  sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
    .win    (win_q),
    .gx_out (k_gx),
    .gy_out (k_gy),
    .mag_out(k_mag)
  );

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    rd_addr_d = rd_addr_q;
    fcnt_d    = fcnt_q;
    win_d     = win_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    gx_d      = gx_q;
    gy_d      = gy_q;
    mag_d     = mag_q;
    enter     = 1'b0;
    nxt_pix   = (state_q == S_IDLE) ? '0 : pix_q + 1'b1;

    unique case (state_q)
      S_IDLE:  enter = start;
      S_FETCH: begin
        fcnt_d = fcnt_q + 1'b1;
        // address for p(k+1) goes out while p(k-1)'s data arrives
        if (fcnt_q < 4'd8) rd_addr_d = win_addr(pix_q, int'(fcnt_q) + 1);
        for (int k = 0; k < 9; k++)
          if (fcnt_q == 4'(k + 1)) win_d[k] = rd_data;
        if (fcnt_q == 4'd9) state_d = S_CALC;
      end
      S_CALC: begin
        gx_d    = k_gx;
        gy_d    = k_gy;
        mag_d   = k_mag;
        wr_en_d = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (pix_q == LAST_PIX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          enter = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Step onto the next pixel: borders go straight to a zero write,
    // interior pixels start fetching with p0's address already out.
    if (enter) begin
      pix_d  = nxt_pix;
      fcnt_d = '0;
      if (is_border(nxt_pix)) begin
        state_d = S_WRITE;
        wr_en_d = 1'b1;
        gx_d    = '0;
        gy_d    = '0;
        mag_d   = '0;
      end else begin
        state_d   = S_FETCH;
        rd_addr_d = win_addr(nxt_pix, 0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      rd_addr_q <= '0;
      fcnt_q    <= '0;
      win_q     <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      mag_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      rd_addr_q <= rd_addr_d;
      fcnt_q    <= fcnt_d;
      win_q     <= win_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      mag_q     <= mag_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = pix_q;
  assign gx_out  = gx_q;
  assign gy_out  = gy_q;
  assign mag_out = mag_q;
  assign done    = done_q;
endmodule

// File: tb/tb_sobel_engine.sv
// Bench for sobel_engine: synchronous gray memory, a reference Sobel model
// computed directly from the image, and a write monitor checked against it.
module tb_sobel_engine;
  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;
  localparam int FRAME_CYC = 10924;

  logic       clk, rst, start;
  logic [3:0] rd_data;
  logic [9:0] rd_addr, wr_addr;
  logic       wr_en, done;
  logic [3:0] gx_out, gy_out, mag_out;

  logic [3:0] mem [0:N-1];

  int checks   = 0;
  int failures = 0;
  int exp_addr = 0;
  int wr_cnt   = 0;

  sobel_engine dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rd_data(rd_data),
    .rd_addr(rd_addr),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .gx_out (gx_out),
    .gy_out (gy_out),
    .mag_out(mag_out),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rd_data <= mem[rd_addr];

  // Reference: {gx, gy, mag} for pixel a, straight from the image
  function automatic logic [11:0] model(input int a);
    int r, c, gx, gy, ax, ay, m;
    int p[9];
    r = a / W;
    c = a % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 12'h000;
    for (int k = 0; k < 9; k++) p[k] = int'(mem[(r + k/3 - 1)*W + c + k%3 - 1]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    m  = (ax + ay) / 4;
    if (m > 15) m = 15;
    return {4'(ax/4), 4'(ay/4), 4'(m)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (wr_en !== 1'b0) begin
        failures++;
        $display("FAIL wr_en_in_reset: got %b expected 0", wr_en);
      end
    end else if (wr_en) begin
      checks++;
      if (int'(wr_addr) != exp_addr) begin
        failures++;
        $display("FAIL wr_addr: got %0d expected %0d", wr_addr, exp_addr);
      end
      checks++;
      if ({gx_out, gy_out, mag_out} !== model(exp_addr)) begin
        failures++;
        $display("FAIL result@%0d: got gx=%0d gy=%0d mag=%0d expected %h",
                 exp_addr, gx_out, gy_out, mag_out, model(exp_addr));
      end
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic fill(input int kind);
    for (int a = 0; a < N; a++) begin
      int r, c;
      r = a / W;
      c = a % W;
      case (kind)
        0: mem[a] = 4'd7;
        1: mem[a] = (c >= 16) ? 4'd15 : 4'd0;
        2: mem[a] = (r >= 16) ? 4'd15 : 4'd0;
        3: mem[a] = (r >= 16 && c >= 16) ? 4'd15 : 4'd0;
        4: mem[a] = 4'(c % 16);
        default: mem[a] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic run_frame(input string name, input bit toggle);
    int cyc;
    bit got;
    exp_addr = 0;
    wr_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < FRAME_CYC + 200 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      if (toggle) start = (cyc < 5000) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, int'(got), 1);
    check({name, "_latency"}, cyc, FRAME_CYC);
    check({name, "_writes"}, wr_cnt, N);
    @(posedge clk);
    #1 check({name, "_done_pulse"}, int'(done), 0);
    repeat (4) @(posedge clk);
    #1 check({name, "_idle_no_writes"}, wr_cnt, N);
  endtask

  initial begin
    int guard;
    rst   = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_outs", int'({gx_out, gy_out, mag_out}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Model pins, hand-computed windows
    fill(1);
    check("pin_vedge_c15", int'(model(10*W + 15)), 12'hF0F);
    check("pin_vedge_c16", int'(model(10*W + 16)), 12'hF0F);
    check("pin_vedge_c17", int'(model(10*W + 17)), 12'h000);
    fill(2);
    check("pin_hedge_r15", int'(model(15*W + 5)), 12'h0FF);
    fill(3);
    check("pin_corner_sat", int'(model(16*W + 16)), 12'hBBF);
    fill(4);
    check("pin_ramp", int'(model(5*W + 5)), 12'h202);
    check("pin_ramp_wrap", int'(model(5*W + 15)), 12'hE0E);
    check("pin_border", int'(model(5*W + 31)), 12'h000);

    fill(0); run_frame("flat", 1'b0);
    fill(1); run_frame("vedge", 1'b0);
    fill(2); run_frame("hedge", 1'b0);
    fill(3); run_frame("corner", 1'b0);
    fill(5); run_frame("random_toggle", 1'b1);

    // Reset while pixel 500 is fetching
    fill(4);
    exp_addr = 0;
    wr_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (!(wr_en && wr_addr == 10'd499) && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_pix499", int'(guard < 8000), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_outs", int'({gx_out, gy_out, mag_out}), 0);
    check("midrst_rd_addr", int'(rd_addr), 0);
    check("midrst_wr_addr", int'(wr_addr), 0);
    check("midrst_done", int'(done), 0);
    guard = wr_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("after_rst_no_writes", wr_cnt, guard);
    run_frame("restart", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
